// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm_if
// Description : Bundle between the multi-cycle MIPS control unit and the
//               shared datapath.
//               Datapath to controller : opcode, funct, mem_ready
//               Controller to datapath : PC/IR/regfile/ALU/memory controls,
//                                        extender mode, debug state, and
//                                        the sticky illegal flag.
//               master : the control FSM.
//               slave  : the datapath (instruction register, memory, muxes).
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, branch_ne, pc_src, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, ext_op, state, illegal
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, pc_src, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, ext_op, state, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle MIPS control unit. Sequences PC, IR, register
//               file, immediate extender, ALU and unified memory, and stalls
//               on the memory ready handshake. An optional watchdog sends the
//               FSM to ILLEGAL when a memory wait lasts TIMEOUT_CYCLES.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - mc_control_fsm_if.master (opcode/funct/mem_ready in,
//                       all datapath controls, state and illegal out)
// Parameters  : TIMEOUT_CYCLES - memory wait limit, 0 disables the watchdog
//               TMR_W          - watchdog counter width
// Macro       : MC_CTRL_BNE_EN - adds bne (opcode 05h) through BRANCH with
//               branch_ne; when undefined, 05h is illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TMR_W          = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mc_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_IMMEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JUMP    = 4'd12,
        S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] c_OP_BNE   = 6'h05;
`endif
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [TMR_W-1:0] c_LIMIT   = TMR_W'(TIMEOUT_CYCLES);
    localparam bit               c_WDOG_EN = (TIMEOUT_CYCLES != 0);

    state_t           r_state;
    logic [5:0]       r_op;
    logic [TMR_W-1:0] r_cnt;

    logic             w_stall;
    logic             w_expire;
    logic [TMR_W-1:0] w_cnt_inc;

    // Only FETCH, MEMRD and MEMWR wait on memory; any other cycle (including
    // the transition into a wait state) leaves the counter cleared.
    assign w_stall   = ((r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR)) && !bus.mem_ready;
    assign w_cnt_inc = r_cnt + TMR_W'(1);
    // A ready on the limit cycle is not a stall, so the normal transition wins.
    assign w_expire  = c_WDOG_EN && w_stall && (w_cnt_inc >= c_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
            r_op    <= '0;
            r_cnt   <= '0;
        end else begin
            r_cnt <= w_stall ? w_cnt_inc : '0;
            if (w_expire) begin
                r_state <= S_ILLEGAL;
            end else begin
                case (r_state)
                    S_RESET:  r_state <= S_FETCH;
                    S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
                    S_DECODE: begin
                        r_op <= bus.opcode;
                        case (bus.opcode)
                            c_OP_LW, c_OP_SW:              r_state <= S_MEMADR;
                            c_OP_RTYPE:                    r_state <= S_EXEC;
                            c_OP_BEQ:                      r_state <= S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                            c_OP_BNE:                      r_state <= S_BRANCH;
`endif
                            c_OP_ADDI, c_OP_ANDI, c_OP_ORI: r_state <= S_IMMEX;
                            c_OP_J:                        r_state <= S_JUMP;
                            default:                       r_state <= S_ILLEGAL;
                        endcase
                    end
                    S_MEMADR: r_state <= (r_op == c_OP_LW) ? S_MEMRD : S_MEMWR;
                    S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
                    S_MEMWB:  r_state <= S_FETCH;
                    S_MEMWR:  if (bus.mem_ready) r_state <= S_FETCH;
                    S_EXEC:   r_state <= S_ALUWB;
                    S_ALUWB:  r_state <= S_FETCH;
                    S_BRANCH: r_state <= S_FETCH;
                    S_IMMEX:  r_state <= S_IMMWB;
                    S_IMMWB:  r_state <= S_FETCH;
                    S_JUMP:   r_state <= S_FETCH;
                    default:  r_state <= S_ILLEGAL;   // ILLEGAL and unused codes are terminal
                endcase
            end
        end
    end

    assign bus.state = r_state;

    // Moore decode of the state register; FETCH additionally gates the IR and
    // PC loads with mem_ready so they only fire when the fetch completes.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_src        = 2'b00;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 3'b000;
        bus.ext_op        = 1'b0;
        bus.illegal       = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.ext_op    = 1'b1;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.ext_op    = 1'b1;
            end
            S_MEMRD: begin
                bus.i_or_d   = 1'b1;
                bus.mem_read = 1'b1;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 3'b010;
            end
            S_ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 3'b001;
                bus.pc_src    = 2'b01;
`ifdef MC_CTRL_BNE_EN
                if (r_op == c_OP_BNE) bus.branch_ne = 1'b1;
                else                  bus.pc_write_cond = 1'b1;
`else
                bus.pc_write_cond = 1'b1;
`endif
            end
            S_IMMEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                // addi sign-extends; the logical immediates zero-extend.
                case (r_op)
                    c_OP_ANDI: bus.alu_op = 3'b011;
                    c_OP_ORI:  bus.alu_op = 3'b100;
                    default:   bus.ext_op = 1'b1;
                endcase
            end
            S_IMMWB:   bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
            end
            S_ILLEGAL: bus.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS control unit; sequences the shared datapath: PC, IR, register file, immediate extender, ALU and unified memory.
- Drives the extender mode (`ext_op`) per instruction and stalls on a memory ready handshake.
- Sits between the instruction register (`opcode`/`funct` taps) and all datapath mux/enable controls.

Parameters:
- TIMEOUT_CYCLES, 0, max cycles to wait for mem_ready in any wait state; 0 disables the watchdog.
- TMR_W, 8, width of the watchdog counter; TIMEOUT_CYCLES must be < 2^TMR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0]; unused by FSM, forwarded for ALU decode only.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- branch_ne  out  1  PC load if ALU not zero.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  out  1  0 PC address, 1 ALUOut address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_dst  out  1  0 rt, 1 rd.
- mem_to_reg  out  1  0 ALUOut, 1 MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 PC, 1 A.
- alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- alu_op  out  3  000 add, 001 sub, 010 funct-decode, 011 and, 100 or.
- ext_op  out  1  1 sign-extend, 0 zero-extend imm[15:0] to 32 bits.
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky fault flag.

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst_n`=0 asynchronously forces state=RESET, clears op_q and the watchdog counter.
  - All outputs are 0 while in RESET.
- Outputs:
  - Decoded combinationally from the state register; `ir_write`/`pc_write` in FETCH are additionally gated by `mem_ready`.
  - Any output not listed for a state is 0.
- State encodings: RESET0, FETCH1, DECODE2, MEMADR3, MEMRD4, MEMWB5, MEMWR6, EXEC7, ALUWB8, BRANCH9, IMMEX10, IMMWB11, JUMP12, ILLEGAL15.
- RESET: next state is FETCH (one idle cycle after reset release).
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=000, pc_src=00; ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_b=11, ext_op=1, alu_op=000; op_q<=opcode.
  - Next state by opcode: 23h/2Bh→MEMADR; 00h→EXEC; 04h→BRANCH; 08h/0Ch/0Dh→IMMEX; 02h→JUMP; any other→ILLEGAL.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=000.
  - Next: op_q=23h→MEMRD, else MEMWR.
- MEMRD: i_or_d=1, mem_read=1; waits for mem_ready, then MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1; next FETCH.
- MEMWR: i_or_d=1, mem_write=1; waits for mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_op=010; next ALUWB.
- ALUWB: reg_dst=1, reg_write=1; next FETCH.
- BRANCH: alu_src_a=1, alu_op=001, pc_src=01, pc_write_cond=1; next FETCH.
- IMMEX:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - op_q=08h: ext_op=1, alu_op=000. op_q=0Ch: ext_op=0, alu_op=011. op_q=0Dh: ext_op=0, alu_op=100.
  - Next IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
- JUMP: pc_write=1, pc_src=10; next FETCH.
- ILLEGAL: illegal=1, all other outputs 0; terminal until reset.
- Latency with mem_ready always 1: lw 5 cycles, sw/R/addi/andi/ori 4, beq/j 3 (FETCH through last state).
- Watchdog:
  - Counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_ready=0 in those states.
  - When the counter reaches TIMEOUT_CYCLES (if nonzero), next state is ILLEGAL.
  - mem_ready=1 on the same cycle as the limit wins: normal transition.
- Reset mid-instruction: the access is abandoned and no write strobe is asserted after rst_n falls.

Optional Feature:
- MC_CTRL_BNE_EN defined:
  - Opcode 05h decodes to BRANCH.
  - In BRANCH, op_q=05h drives branch_ne=1 and pc_write_cond=0.
- Not defined: branch_ne is tied 0 and opcode 05h goes to ILLEGAL.

Test Plan:
- Reset: rst_n=0 with clk running → state=0, all outputs 0; release → FETCH on next edge, mem_read=1.
- lw 8C220004 with mem_ready=1 → state sequence 1,2,3,4,5,1; ext_op=1 in MEMADR; reg_write=1 and mem_to_reg=1 in MEMWB only.
- ori 3442FFFF, then addi 2042FFE2 → IMMEX ext_op=0/alu_op=100 for ori, then ext_op=1/alu_op=000 for addi.
- sw with mem_ready held 0 for 3 cycles, TIMEOUT_CYCLES=0 → MEMWR held 4 cycles, mem_write=1 throughout, then FETCH.
- Same stall with TIMEOUT_CYCLES=2 → ILLEGAL after 2 stalled cycles, illegal=1 sticky until rst_n pulse.
- Opcode 05h → ILLEGAL without MC_CTRL_BNE_EN; BRANCH with branch_ne=1 and pc_write_cond=0 when defined.
